acc_reset_sequencer: RTL
========================

Name: acc_reset_sequencer

Overview:
Consumes the one-cycle active-low software reset command (acc_sw_reset_n) from the AXI-lite hardware-info/command slave. Turns it into an ordered accelerator reset: quiesce traffic, drain until idle or timeout, hold reset, then release accelerators one at a time. Sits between the HwInfo command slave and the per-accelerator reset inputs and interconnect gating.

Parameters:
NUM_ACC, 4, number of accelerator reset domains (>=1)
HOLD_CYCLES, 16, cycles all acc resets are held low (>=1)
STAGGER_CYCLES, 4, cycles between consecutive acc releases (>=1)
DRAIN_TIMEOUT, 1024, max cycles spent waiting for idle (>=1)
CNT_WIDTH, 16, width of the software-reset event counter

Ports:
S_AXI_ACLK_i  in  1  clock
S_AXI_ARESETN_i  in  1  system reset
sw_reset_req_n_i  in  1  command from the HwInfo slave's acc_sw_reset_n; active-low pulse
acc_idle_i  in  NUM_ACC  per-accelerator idle (no outstanding transactions)
quiesce_o  out  1  high = interconnect must stop issuing new requests to accelerators
acc_rst_n_o  out  NUM_ACC  per-accelerator active-low reset
busy_o  out  1  sequence in progress (state != IDLE)
timeout_o  out  1  last drain ended by timeout, not by idle
reset_count_o  out  CNT_WIDTH  number of software resets accepted, saturating

Behaviour:
- Reset is S_AXI_ARESETN_i, asynchronous, active-low; clock is S_AXI_ACLK_i. All state and outputs are registered.
- Reset values: state=ASSERT, acc_rst_n_o=0, quiesce_o=1, busy_o=1, timeout_o=0, reset_count_o=0, req_prev=0, pending=0, all counters 0.
- Power-on: the sequencer runs ASSERT then RELEASE with no software request, so accelerators come up staggered.
- Request detect: req = (sw_reset_req_n_i==0 && req_prev==1); req_prev <= sw_reset_req_n_i. The command slave drives its output low for one cycle after system reset. req_prev resets to 0, so that pulse is not a request.
- States: IDLE, DRAIN, ASSERT, RELEASE.
- IDLE: acc_rst_n_o all 1, quiesce_o=0. On req (or pending=1) at cycle t: state=DRAIN at t+1, pending cleared, timeout_o cleared, reset_count_o += 1 (saturates at all-ones).
- DRAIN (entry cycle D): quiesce_o=1 and acc_rst_n_o stays all 1.
  - If &acc_idle_i is sampled 1 in any DRAIN cycle, go to ASSERT the next cycle.
  - Otherwise, after DRAIN_TIMEOUT cycles (cycles D..D+DRAIN_TIMEOUT-1), go to ASSERT at D+DRAIN_TIMEOUT and set timeout_o=1 in that same cycle.
- ASSERT (entry cycle A): acc_rst_n_o all 0 during cycles A..A+HOLD_CYCLES-1. Then go to RELEASE.
- RELEASE (entry cycle E=A+HOLD_CYCLES): acc_rst_n_o[i] goes 1 from cycle E+i*STAGGER_CYCLES, releasing index 0 first. A released bit stays 1.
  - State returns to IDLE at E+(NUM_ACC-1)*STAGGER_CYCLES+1; quiesce_o and busy_o drop to 0 in that cycle.
- quiesce_o=1 in DRAIN, ASSERT and RELEASE.
- Request while busy: sets pending=1. Multiple requests merge into one pending. Pending is serviced on the first IDLE cycle, which behaves as a req.
- A req in the same cycle the state returns to IDLE is treated as pending and is serviced one cycle later.
- acc_idle_i is ignored outside DRAIN.
- Counter widths: $clog2 of the largest count + 1. No wrap occurs within a phase.
- System reset mid-sequence: asynchronous return to the reset values above, then a fresh power-on ASSERT/RELEASE. reset_count_o is lost.

Optional Feature:
ACC_RST_IDLE_SYNC_EN: when defined, acc_idle_i passes through a 2-flop synchronizer per bit (flops reset to 0) before the DRAIN check, so idle is seen 2 cycles later. Without it, acc_idle_i is used directly and must be synchronous to S_AXI_ACLK_i. Timeout counting is unchanged in both cases.

Decomposition:
- Package acc_reset_pkg: state enum (IDLE, DRAIN, ASSERT, RELEASE) and a helper function for counter width.
- One sub-module, acc_idle_sync: per-bit 2-flop synchronizer, instantiated only under ACC_RST_IDLE_SYNC_EN.

Test Plan:
1. Power-on: deassert reset while sw_reset_req_n_i is 0 for the first cycle. Expect acc_rst_n_o=0000 for 16 cycles, then bits rise at +0/+4/+8/+12, busy_o falls 1 cycle after the last rise, reset_count_o=0.
2. Normal reset: acc_idle_i=1111, 1-cycle low pulse at t. Expect quiesce_o=1 at t+1, acc_rst_n_o=0000 at t+2..t+17, acc0 high at t+18, acc3 high at t+30, IDLE at t+31, reset_count_o=1, timeout_o=0.
3. Timeout: DRAIN_TIMEOUT=8, acc_idle_i=0111 held. Expect ASSERT at D+8, timeout_o=1. A later request with all idle clears timeout_o.
4. Pending: three pulses during RELEASE. Expect exactly one extra sequence immediately after IDLE, reset_count_o=2.
5. Mid-sequence reset: assert S_AXI_ARESETN_i during ASSERT. Expect immediate acc_rst_n_o=0, quiesce_o=1, reset_count_o=0, then a power-on sequence.
6. ACC_RST_IDLE_SYNC_EN defined: idle rises at cycle D. Expect ASSERT at D+3 (vs D+1 without the macro).

Source files
------------

// File: rtl/acc_reset_pkg.sv
// Shared types and helpers for the accelerator reset sequencer.
package acc_reset_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StAssert,
        StRelease
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/acc_reset_sequencer_if.sv
// Command, idle and reset-control signals between the HwInfo slave, accelerators and sequencer.
interface acc_reset_sequencer_if #(
    parameter int unsigned NUM_ACC   = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 sw_reset_req_n;
    logic [NUM_ACC-1:0]   acc_idle;
    logic                 quiesce;
    logic [NUM_ACC-1:0]   acc_rst_n;
    logic                 busy;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] reset_count;

    modport slave (
        input  sw_reset_req_n, acc_idle,
        output quiesce, acc_rst_n, busy, timeout, reset_count
    );

    modport master (
        output sw_reset_req_n, acc_idle,
        input  quiesce, acc_rst_n, busy, timeout, reset_count
    );
endinterface

// File: rtl/acc_idle_sync.sv
// Per-bit two-flop synchronizer for the accelerator idle flags.
module acc_idle_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/acc_reset_sequencer.sv
// Ordered accelerator reset: quiesce, drain, hold, staggered release.
// Define ACC_RST_IDLE_SYNC_EN to synchronize acc_idle through two flops first.
module acc_reset_sequencer
    import acc_reset_pkg::*;
#(
    parameter int unsigned NUM_ACC        = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT  = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input logic                  S_AXI_ACLK_i,
    input logic                  S_AXI_ARESETN_i,
    acc_reset_sequencer_if.slave bus
);
    localparam int unsigned MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
    localparam int unsigned CW = cnt_width(MAX_CNT);
    localparam int unsigned IW = cnt_width(NUM_ACC);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_ACC - 1);

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 req_prev;
    logic                 pending;
    logic                 quiesce;
    logic [NUM_ACC-1:0]   acc_rst_n;
    logic                 busy;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] reset_count;
    logic                 req;
    logic                 idle_all;

`ifdef ACC_RST_IDLE_SYNC_EN
    logic [NUM_ACC-1:0] idle_sync;

    acc_idle_sync #(
        .WIDTH (NUM_ACC)
    ) u_idle_sync (
        .clk   (S_AXI_ACLK_i),
        .rst_n (S_AXI_ARESETN_i),
        .din   (bus.acc_idle),
        .dout  (idle_sync)
    );

    assign idle_all = &idle_sync;
`else
    assign idle_all = &bus.acc_idle;
`endif

    // req_prev resets low so the slave's post-reset low cycle is not a request.
    assign req = !bus.sw_reset_req_n && req_prev;

    always_ff @(posedge S_AXI_ACLK_i or negedge S_AXI_ARESETN_i) begin
        if (!S_AXI_ARESETN_i) begin
            state       <= StAssert;
            cnt         <= '0;
            idx         <= '0;
            req_prev    <= 1'b0;
            pending     <= 1'b0;
            quiesce     <= 1'b1;
            acc_rst_n   <= '0;
            busy        <= 1'b1;
            timeout     <= 1'b0;
            reset_count <= '0;
        end else begin
            req_prev <= bus.sw_reset_req_n;
            if (req && state != StIdle) pending <= 1'b1;

            unique case (state)
                StIdle: begin
                    if (req || pending) begin
                        state   <= StDrain;
                        pending <= 1'b0;
                        timeout <= 1'b0;
                        quiesce <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        if (!(&reset_count)) reset_count <= reset_count + 1'b1;
                    end
                end
                StDrain: begin
                    if (idle_all || cnt == DRAIN_LAST) begin
                        state     <= StAssert;
                        acc_rst_n <= '0;
                        timeout   <= !idle_all;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StAssert: begin
                    if (cnt == HOLD_LAST) begin
                        state     <= StRelease;
                        acc_rst_n <= NUM_ACC'(1);
                        idx       <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRelease: begin
                    if (idx == IDX_LAST) begin
                        state   <= StIdle;
                        quiesce <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cnt == STAGGER_LAST) begin
                        // Shift in the next released domain; lower indices stay high.
                        acc_rst_n <= (acc_rst_n << 1) | NUM_ACC'(1);
                        idx       <= idx + 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.quiesce     = quiesce;
    assign bus.acc_rst_n   = acc_rst_n;
    assign bus.busy        = busy;
    assign bus.timeout     = timeout;
    assign bus.reset_count = reset_count;
endmodule
